instr_fetch: RTL and testbench

Fetch controller that produces the instruction word and load strobe consumed by the instruction register.
- Holds the program counter and issues single-word reads to instruction memory over a req/ack handshake.
- Delivers the returned word with a one-cycle ir_ld pulse.
- Sits between the control unit (fetch_en, pc_ld) and the instruction memory; its instruction/ir_ld outputs drive the IR's instruction/IR_ld inputs directly.

---
 rtl/instr_fetch_pkg.sv | 15 +
 rtl/instr_fetch_pc_counter.sv | 28 ++
 rtl/instr_fetch.sv | 160 ++++++++++++++++
 tb/tb_instr_fetch.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/instr_fetch_pkg.sv
// Shared definitions for the instruction fetch controller: state encoding
// and default widths / reset PC.
package instr_fetch_pkg;

    localparam int ADDR_W_DEF   = 16;
    localparam int DATA_W_DEF   = 16;
    localparam int RESET_PC_DEF = 0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_LOAD = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/instr_fetch_pc_counter.sv
// Program counter register: async reset to RESET_PC, parallel load,
// and +1 increment that wraps at 2^ADDR_W. Load has priority over increment.
module pc_counter
    import instr_fetch_pkg::*;
#(
    parameter int                ADDR_W   = ADDR_W_DEF,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEF)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [ADDR_W-1:0] load_val,
    input  logic              inc,
    output logic [ADDR_W-1:0] pc
);

    // PC register: load wins over increment; increment wraps naturally
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc <= RESET_PC;
        end else if (load) begin
            pc <= load_val;
        end else if (inc) begin
            pc <= pc + ADDR_W'(1);
        end
    end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch controller. Issues single-word reads over a req/ack
// handshake and hands the returned word to the IR with a one-cycle ir_ld.
//
//   state   | meaning
//   --------+------------------------------------------------------------
//   IDLE    | waiting for fetch_en; pc_ld redirects the PC directly
//   REQ     | imem_req held with a stable address until imem_ack
//   LOAD    | ir_ld high for this single cycle, then back to IDLE
//
// A pc_ld seen during REQ cannot cancel the outstanding memory read, so the
// target is parked in redirect_addr and the squash flag marks the returning
// word as stale: it is dropped and the PC takes the parked target instead.
module instr_fetch
    import instr_fetch_pkg::*;
#(
    parameter int                ADDR_W   = ADDR_W_DEF,
    parameter int                DATA_W   = DATA_W_DEF,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEF)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              fetch_en,
    input  logic              pc_ld,
    input  logic [ADDR_W-1:0] pc_target,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [DATA_W-1:0] imem_rdata,
    output logic              ir_ld,
    output logic [DATA_W-1:0] instruction,
    output logic [ADDR_W-1:0] pc,
    output logic              fetch_busy
);

    fetch_state_t state, state_nxt;

    logic [ADDR_W-1:0] redirect_addr, redirect_addr_nxt;
    logic              squash, squash_nxt;
    logic              imem_req_nxt;
    logic [ADDR_W-1:0] imem_addr_nxt;
    logic              ir_ld_nxt;
    logic [DATA_W-1:0] instruction_nxt;

    logic              pc_load;
    logic [ADDR_W-1:0] pc_load_val;
    logic              pc_inc;

    // A pc_ld in the ack cycle itself still squashes and is the newest target
    logic              squash_now;
    logic [ADDR_W-1:0] target_now;

    assign squash_now = squash | pc_ld;
    assign target_now = pc_ld ? pc_target : redirect_addr;
    assign fetch_busy = (state != ST_IDLE);

    pc_counter #(
        .ADDR_W   (ADDR_W),
        .RESET_PC (RESET_PC)
    ) u_pc_counter (
        .clk      (clk),
        .rst      (rst),
        .load     (pc_load),
        .load_val (pc_load_val),
        .inc      (pc_inc),
        .pc       (pc)
    );

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (fetch_en) state_nxt = ST_REQ;
            ST_REQ:  if (imem_ack) state_nxt = squash_now ? ST_IDLE : ST_LOAD;
            ST_LOAD: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Output / datapath next values per state
    always_comb begin
        imem_req_nxt      = imem_req;
        imem_addr_nxt     = imem_addr;
        ir_ld_nxt         = 1'b0;
        instruction_nxt   = instruction;
        redirect_addr_nxt = redirect_addr;
        squash_nxt        = squash;
        pc_load           = 1'b0;
        pc_load_val       = pc_target;
        pc_inc            = 1'b0;
        case (state)
            ST_IDLE: begin
                squash_nxt = 1'b0;
                if (pc_ld) begin
                    pc_load = 1'b1;
                end
                if (fetch_en) begin
                    imem_req_nxt  = 1'b1;
                    imem_addr_nxt = pc_ld ? pc_target : pc;
                end
            end
            ST_REQ: begin
                if (pc_ld) begin
                    redirect_addr_nxt = pc_target;
                    squash_nxt        = 1'b1;
                end
                if (imem_ack) begin
                    imem_req_nxt = 1'b0;
                    squash_nxt   = 1'b0;
                    if (squash_now) begin
                        pc_load     = 1'b1;
                        pc_load_val = target_now;
                    end else begin
                        // pc equals imem_addr throughout REQ, so pc+1 is addr+1
                        instruction_nxt = imem_rdata;
                        ir_ld_nxt       = 1'b1;
                        pc_inc          = 1'b1;
                    end
                end
            end
            ST_LOAD: begin
                if (pc_ld) begin
                    pc_load = 1'b1;
                end
            end
            default: begin
                imem_req_nxt = 1'b0;
                squash_nxt   = 1'b0;
            end
        endcase
    end

    // Registered outputs and redirect bookkeeping
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            imem_req      <= 1'b0;
            imem_addr     <= '0;
            ir_ld         <= 1'b0;
            instruction   <= '0;
            redirect_addr <= '0;
            squash        <= 1'b0;
        end else begin
            imem_req      <= imem_req_nxt;
            imem_addr     <= imem_addr_nxt;
            ir_ld         <= ir_ld_nxt;
            instruction   <= instruction_nxt;
            redirect_addr <= redirect_addr_nxt;
            squash        <= squash_nxt;
        end
    end

endmodule

// File: tb/tb_instr_fetch.sv
// Scoreboarded bench for instr_fetch: stimulus pushes expected requests and
// deliveries into queues; a monitor pops and compares them as the DUT
// presents imem_req and ir_ld.
module tb_instr_fetch;

    logic        clk = 1'b0;
    logic        rst;
    logic        fetch_en;
    logic        pc_ld;
    logic [15:0] pc_target;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_ack;
    logic [15:0] imem_rdata;
    logic        ir_ld;
    logic [15:0] instruction;
    logic [15:0] pc;
    logic        fetch_busy;

    instr_fetch #(
        .ADDR_W   (16),
        .DATA_W   (16),
        .RESET_PC (16'h0000)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .fetch_en    (fetch_en),
        .pc_ld       (pc_ld),
        .pc_target   (pc_target),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .ir_ld       (ir_ld),
        .instruction (instruction),
        .pc          (pc),
        .fetch_busy  (fetch_busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] addr;
        int          len;     // expected imem_req high cycles, -1 = aborted
    } req_t;

    typedef struct {
        logic [15:0] instr;
        logic [15:0] pc;
    } ld_t;

    req_t req_q[$];
    ld_t  ld_q[$];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int last_ld_cyc = 0;
    int ld_gap = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic monitor();
        logic        req_prev = 1'b0;
        int          cnt = 0;
        int          exp_len = -1;
        logic [15:0] held = '0;
        req_t        r;
        ld_t         l;
        forever begin
            @(negedge clk);
            cyc++;
            if (imem_req) begin
                if (!req_prev) begin
                    if (req_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_req: addr 0x%0h, none expected", imem_addr);
                        exp_len = -1;
                    end else begin
                        r = req_q.pop_front();
                        chk("req_addr", 32'(imem_addr), 32'(r.addr));
                        exp_len = r.len;
                    end
                    held = imem_addr;
                    cnt  = 1;
                end else begin
                    cnt++;
                    chk("req_addr_stable", 32'(imem_addr), 32'(held));
                end
            end else if (req_prev && exp_len >= 0) begin
                chk("req_len", 32'(cnt), 32'(exp_len));
            end
            if (ir_ld) begin
                if (ld_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_ir_ld: instruction 0x%0h, none expected", instruction);
                end else begin
                    l = ld_q.pop_front();
                    chk("ld_instruction", 32'(instruction), 32'(l.instr));
                    chk("ld_pc", 32'(pc), 32'(l.pc));
                end
                ld_gap      = cyc - last_ld_cyc;
                last_ld_cyc = cyc;
            end
            req_prev = imem_req;
        end
    endtask

    // Starts and ends at posedge+1 with the DUT in IDLE
    task automatic do_fetch(input logic use_ld, input logic [15:0] tgt, input int waits,
                            input logic [15:0] rdata, input logic [15:0] exp_addr,
                            input logic [15:0] exp_pc);
        req_q.push_back('{exp_addr, waits + 1});
        ld_q.push_back('{rdata, exp_pc});
        fetch_en  = 1'b1;
        pc_ld     = use_ld;
        pc_target = tgt;
        @(posedge clk); #1;
        fetch_en = 1'b0;
        pc_ld    = 1'b0;
        repeat (waits) begin
            @(posedge clk); #1;
        end
        imem_ack   = 1'b1;
        imem_rdata = rdata;
        @(posedge clk); #1;
        imem_ack   = 1'b0;
        imem_rdata = 16'h0000;
        @(posedge clk); #1;
    endtask

    task automatic step();
        @(posedge clk); #1;
    endtask

    initial begin
        rst        = 1'b1;
        fetch_en   = 1'b0;
        pc_ld      = 1'b0;
        pc_target  = 16'h0000;
        imem_ack   = 1'b0;
        imem_rdata = 16'h0000;
        fork
            monitor();
        join_none

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_imem_req", 32'(imem_req), 32'd0);
        chk("rst_imem_addr", 32'(imem_addr), 32'd0);
        chk("rst_ir_ld", 32'(ir_ld), 32'd0);
        chk("rst_instruction", 32'(instruction), 32'd0);
        chk("rst_pc", 32'(pc), 32'd0);
        chk("rst_fetch_busy", 32'(fetch_busy), 32'd0);
        step();
        rst = 1'b0;
        step();

        // Two wait cycles before ack
        do_fetch(1'b0, 16'h0000, 2, 16'hA5C3, 16'h0000, 16'h0001);
        @(negedge clk);
        chk("t1_instruction_held", 32'(instruction), 32'hA5C3);
        chk("t1_pc", 32'(pc), 32'h0001);
        step();

        // Back-to-back zero-wait fetches from reset
        rst = 1'b1;
        step();
        rst = 1'b0;
        step();
        do_fetch(1'b0, 16'h0000, 0, 16'h1111, 16'h0000, 16'h0001);
        do_fetch(1'b0, 16'h0000, 0, 16'h2222, 16'h0001, 16'h0002);
        chk("t2_ld_period_a", 32'(ld_gap), 32'd3);
        do_fetch(1'b0, 16'h0000, 0, 16'h3333, 16'h0002, 16'h0003);
        chk("t2_ld_period_b", 32'(ld_gap), 32'd3);

        // fetch_en with pc_ld in IDLE
        do_fetch(1'b1, 16'h0040, 1, 16'h1234, 16'h0040, 16'h0041);

        // Redirect while waiting: returned word is dropped
        req_q.push_back('{16'h0041, 2});
        fetch_en = 1'b1;
        step();
        fetch_en  = 1'b0;
        pc_ld     = 1'b1;
        pc_target = 16'h0100;
        step();
        pc_ld      = 1'b0;
        imem_ack   = 1'b1;
        imem_rdata = 16'hFFFF;
        step();
        imem_ack = 1'b0;
        @(negedge clk);
        chk("t4_pc", 32'(pc), 32'h0100);
        chk("t4_instruction_kept", 32'(instruction), 32'h1234);
        chk("t4_idle", 32'(fetch_busy), 32'd0);
        step();

        // Two redirects, the second in the ack cycle: last one wins
        req_q.push_back('{16'h0100, 2});
        fetch_en = 1'b1;
        step();
        fetch_en  = 1'b0;
        pc_ld     = 1'b1;
        pc_target = 16'h0200;
        step();
        pc_target  = 16'h0300;
        imem_ack   = 1'b1;
        imem_rdata = 16'h5555;
        step();
        pc_ld    = 1'b0;
        imem_ack = 1'b0;
        @(negedge clk);
        chk("t4b_pc_last_wins", 32'(pc), 32'h0300);
        chk("t4b_instruction_kept", 32'(instruction), 32'h1234);
        chk("t4b_idle", 32'(fetch_busy), 32'd0);
        step();

        // pc_ld alone in IDLE, then fetch at top of address space
        pc_ld     = 1'b1;
        pc_target = 16'hFFFF;
        step();
        pc_ld = 1'b0;
        @(negedge clk);
        chk("t5_pc_redirect", 32'(pc), 32'hFFFF);
        chk("t5_no_req", 32'(imem_req), 32'd0);
        chk("t5_idle", 32'(fetch_busy), 32'd0);
        step();
        do_fetch(1'b0, 16'h0000, 1, 16'hBEEF, 16'hFFFF, 16'h0000);

        // pc_ld in LOAD overrides +1; fetch_en in LOAD ignored; stray ack ignored
        req_q.push_back('{16'h0000, 1});
        ld_q.push_back('{16'h0F0F, 16'h0001});
        fetch_en = 1'b1;
        step();
        fetch_en   = 1'b0;
        imem_ack   = 1'b1;
        imem_rdata = 16'h0F0F;
        step();
        imem_ack  = 1'b0;
        fetch_en  = 1'b1;
        pc_ld     = 1'b1;
        pc_target = 16'h0ABC;
        step();
        fetch_en   = 1'b0;
        pc_ld      = 1'b0;
        imem_ack   = 1'b1;
        imem_rdata = 16'h9999;
        step();
        imem_ack = 1'b0;
        step();
        @(negedge clk);
        chk("t5b_pc_load_override", 32'(pc), 32'h0ABC);
        chk("t5b_no_refetch", 32'(imem_req), 32'd0);
        chk("t5b_instruction", 32'(instruction), 32'h0F0F);
        step();

        // Reset while in REQ, ack after release
        req_q.push_back('{16'h0ABC, -1});
        fetch_en = 1'b1;
        step();
        fetch_en = 1'b0;
        step();
        rst = 1'b1;
        #2;
        chk("t6_rst_imem_req", 32'(imem_req), 32'd0);
        chk("t6_rst_imem_addr", 32'(imem_addr), 32'd0);
        chk("t6_rst_pc", 32'(pc), 32'd0);
        chk("t6_rst_busy", 32'(fetch_busy), 32'd0);
        chk("t6_rst_instruction", 32'(instruction), 32'd0);
        chk("t6_rst_ir_ld", 32'(ir_ld), 32'd0);
        step();
        rst        = 1'b0;
        imem_ack   = 1'b1;
        imem_rdata = 16'h7777;
        step();
        imem_ack = 1'b0;
        repeat (2) step();
        @(negedge clk);
        chk("t6_pc_after", 32'(pc), 32'd0);
        chk("t6_instruction_after", 32'(instruction), 32'd0);
        chk("t6_idle_after", 32'(fetch_busy), 32'd0);

        chk("ld_queue_drained", 32'(ld_q.size()), 32'd0);
        chk("req_queue_drained", 32'(req_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
